// File: rtl/cus42_pkg.sv
// Shared definitions for the CUS42 scroll-layer block: fetch phases,
// CPU register offsets and tile-map geometry.
package cus42_pkg;

    typedef enum logic [1:0] {
        PH_ADDR0       = 2'd0,
        PH_CODE0       = 2'd1,
        PH_ATTR0_ADDR1 = 2'd2,
        PH_CODE1       = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        REG_HLO = 2'd0,
        REG_HHI = 2'd1,
        REG_VLO = 2'd2,
        REG_VHI = 2'd3
    } reg_e;

    localparam int TILE_COL_BITS = 6;
    localparam int TILE_ROW_BITS = 5;

endpackage

// File: rtl/cus42_scroll_regs.sv
// One layer's double-buffered H/V scroll registers and scroll adders.
// CUS42_VFLIP_EN: screen flip also mirrors the vertical axis.
module cus42_scroll_regs
    import cus42_pkg::*;
#(
    parameter int FLIP_H_BASE = 384
`ifdef CUS42_VFLIP_EN
    ,
    parameter int FLIP_V_BASE = 264
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       flip,
    input  logic [8:0] h,
    input  logic [8:0] v,
    output logic [8:0] sh,
    output logic [8:0] sv
);

    logic [8:0] hs_shd_q, hs_shd_d;
    logic [8:0] vs_shd_q, vs_shd_d;
    logic [8:0] hs_act_q, hs_act_d;
    logic [8:0] vs_act_q, vs_act_d;
    logic [8:0] fh, sh_sum;
`ifdef CUS42_VFLIP_EN
    logic [8:0] fv, sv_sum;
`endif

    always_comb begin
        hs_shd_d = hs_shd_q;
        vs_shd_d = vs_shd_q;
        hs_act_d = hs_act_q;
        vs_act_d = vs_act_q;
        // Commit copies the shadow as it stood before this clock's CPU write.
        if (commit) begin
            hs_act_d = hs_shd_q;
            vs_act_d = vs_shd_q;
        end
        if (wr_en) begin
            unique case (reg_e'(wr_addr))
                REG_HLO: hs_shd_d[7:0] = wr_data;
                REG_HHI: hs_shd_d[8]   = wr_data[0];
                REG_VLO: vs_shd_d[7:0] = wr_data;
                REG_VHI: vs_shd_d[8]   = wr_data[0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_shd_q <= '0;
            vs_shd_q <= '0;
            hs_act_q <= '0;
            vs_act_q <= '0;
        end else begin
            hs_shd_q <= hs_shd_d;
            vs_shd_q <= vs_shd_d;
            hs_act_q <= hs_act_d;
            vs_act_q <= vs_act_d;
        end
    end

    always_comb begin
        fh     = flip ? (9'(FLIP_H_BASE) - h) : h;
        sh_sum = hs_act_q + fh;
        sh     = {sh_sum[8:3], sh_sum[2:0] ^ {3{flip}}};
`ifdef CUS42_VFLIP_EN
        fv     = flip ? (9'(FLIP_V_BASE) - v) : v;
        sv_sum = vs_act_q + fv;
        sv     = {sv_sum[8:3], sv_sum[2:0] ^ {3{flip}}};
`else
        sv     = vs_act_q + v;
`endif
    end

endmodule

// File: rtl/cus42_scroll_layers.sv
// CUS42 scroll-layer block: NUM_LAYERS tilemap layers sharing one tile-name SRAM port.
// CUS42_VFLIP_EN: screen flip also mirrors the vertical scroll axis.
module cus42_scroll_layers
    import cus42_pkg::*;
#(
    parameter int NUM_LAYERS  = 2,
    parameter int LAYER_BASE  = 0,
    parameter int FLIP_H_BASE = 384,
    parameter int FLIP_V_BASE = 264,
    parameter int H_COMMIT    = 384,
    parameter int GA_W        = 14
) (
    input  logic                       CLK_6M,
    input  logic                       nRST,
    input  logic                       FLIP,
    input  logic                       nLATCH,
    input  logic [2:0]                 CA,
    input  logic [7:0]                 CD,
    input  logic [7:0]                 RD,
    input  logic [8:0]                 H,
    input  logic [8:0]                 V,
    output logic [11:0]                RA,
    output logic [NUM_LAYERS*GA_W-1:0] GA,
    output logic                       S3H
);

    localparam logic [8:0] H_COMMIT_9 = 9'(H_COMMIT);
    localparam logic       LAYER0_SEL = 1'(LAYER_BASE);

    if (NUM_LAYERS < 1 || NUM_LAYERS > 2) begin : g_bad_layers
        $error("cus42_scroll_layers: NUM_LAYERS must be 1 or 2");
    end
    if (GA_W < 12 || GA_W > 20) begin : g_bad_ga_w
        $error("cus42_scroll_layers: GA_W must be 12..20");
    end
    if (FLIP_V_BASE < 0 || FLIP_V_BASE > 511) begin : g_bad_vbase
        $error("cus42_scroll_layers: FLIP_V_BASE must be 0..511");
    end

    phase_e      phase;
    logic        nlatch_q, nlatch_d;
    logic        wr_stb, commit;
    logic [11:0] ra_q, ra_d;
    logic        s3h_q, s3h_d;
    logic [8:0]  sh      [NUM_LAYERS];
    logic [8:0]  sv      [NUM_LAYERS];
    logic [11:0] ra_even [NUM_LAYERS];

    assign phase    = phase_e'(H[1:0]);
    assign nlatch_d = nLATCH;
    assign wr_stb   = nlatch_q & ~nLATCH;
    assign commit   = (H == H_COMMIT_9);

    for (genvar n = 0; n < NUM_LAYERS; n++) begin : g_layer
        // Layer 1 runs the same fetch two phases behind layer 0.
        localparam logic   SEL     = LAYER0_SEL ^ 1'(n);
        localparam phase_e PH_NIB  = phase_e'((n == 0) ? PH_ADDR0 : PH_ATTR0_ADDR1);
        localparam phase_e PH_CODE = phase_e'((n == 0) ? PH_CODE0 : PH_CODE1);
        localparam phase_e PH_GA   = phase_e'((n == 0) ? PH_ATTR0_ADDR1 : PH_ADDR0);

        logic            wr_en;
        logic [7:0]      code_q, code_d;
        logic [3:0]      nib_q, nib_d;
        logic [GA_W-1:0] ga_q, ga_d;
        logic [GA_W-5:0] attr_code;
        logic            unused_scroll_bits;

        assign wr_en = wr_stb & (CA[2] == SEL);

        cus42_scroll_regs #(
            .FLIP_H_BASE(FLIP_H_BASE)
`ifdef CUS42_VFLIP_EN
            ,
            .FLIP_V_BASE(FLIP_V_BASE)
`endif
        ) u_regs (
            .clk    (CLK_6M),
            .rst_n  (nRST),
            .wr_en  (wr_en),
            .wr_addr(CA[1:0]),
            .wr_data(CD),
            .commit (commit),
            .flip   (FLIP),
            .h      (H),
            .v      (V),
            .sh     (sh[n]),
            .sv     (sv[n])
        );

        assign ra_even[n]         = {sv[n][TILE_ROW_BITS+2:3], sh[n][TILE_COL_BITS+2:3], 1'b0};
        assign unused_scroll_bits = ^{sv[n][8], sh[n][1:0]};

        if (GA_W > 12) begin : g_attr
            assign attr_code = {RD[GA_W-13:0], code_q};
        end else begin : g_no_attr
            assign attr_code = code_q;
        end

        always_comb begin
            code_d = code_q;
            nib_d  = nib_q;
            ga_d   = ga_q;
            if (phase == PH_NIB)  nib_d  = {sv[n][2:0], sh[n][2]};
            if (phase == PH_CODE) code_d = RD;
            if (phase == PH_GA)   ga_d   = {attr_code, nib_q};
        end

        always_ff @(posedge CLK_6M or negedge nRST) begin
            if (!nRST) begin
                code_q <= '0;
                nib_q  <= '0;
                ga_q   <= '0;
            end else begin
                code_q <= code_d;
                nib_q  <= nib_d;
                ga_q   <= ga_d;
            end
        end

        assign GA[n*GA_W +: GA_W] = ga_q;
    end

    always_comb begin
        ra_d = ra_q;
        unique case (phase)
            PH_ADDR0:       ra_d = ra_even[0];
            PH_CODE0:       ra_d[0] = 1'b1;
            PH_ATTR0_ADDR1: if (NUM_LAYERS > 1) ra_d = ra_even[NUM_LAYERS-1];
            PH_CODE1:       if (NUM_LAYERS > 1) ra_d[0] = 1'b1;
        endcase
        s3h_d = (phase == PH_CODE1);
    end

    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            nlatch_q <= 1'b1;
            ra_q     <= '0;
            s3h_q    <= 1'b0;
        end else begin
            nlatch_q <= nlatch_d;
            ra_q     <= ra_d;
            s3h_q    <= s3h_d;
        end
    end

    assign RA  = ra_q;
    assign S3H = s3h_q;

endmodule

// File: tb/tb_cus42_scroll_layers.sv
// Directed bench for cus42_scroll_layers: a two-layer and a one-layer instance
// share stimulus; expected values are hand-computed constants.
module tb_cus42_scroll_layers;

`ifdef CUS42_VFLIP_EN
    localparam logic [11:0] EXP_FLIP_RA0  = 12'h0E0;
    localparam logic [13:0] EXP_FLIP_GA0  = 14'h0ABF;
    localparam logic [11:0] EXP_FLIP_RA4  = 12'h0DE;
`else
    localparam logic [11:0] EXP_FLIP_RA0  = 12'h060;
    localparam logic [13:0] EXP_FLIP_GA0  = 14'h0AB1;
    localparam logic [11:0] EXP_FLIP_RA4  = 12'h05E;
`endif

    logic        CLK_6M;
    logic        nRST;
    logic        FLIP;
    logic        nLATCH;
    logic [2:0]  CA;
    logic [7:0]  CD;
    logic [7:0]  RD;
    logic [8:0]  H;
    logic [8:0]  V;
    logic [11:0] RA;
    logic [27:0] GA;
    logic        S3H;
    logic [11:0] RA_1L;
    logic [13:0] GA_1L;
    logic        S3H_1L;

    int unsigned n_checks;
    int unsigned n_errors;

    cus42_scroll_layers #(.NUM_LAYERS(2), .GA_W(14)) dut (
        .CLK_6M(CLK_6M), .nRST(nRST), .FLIP(FLIP), .nLATCH(nLATCH),
        .CA(CA), .CD(CD), .RD(RD), .H(H), .V(V),
        .RA(RA), .GA(GA), .S3H(S3H)
    );

    cus42_scroll_layers #(.NUM_LAYERS(1), .GA_W(14)) dut_1l (
        .CLK_6M(CLK_6M), .nRST(nRST), .FLIP(FLIP), .nLATCH(nLATCH),
        .CA(CA), .CD(CD), .RD(RD), .H(H), .V(V),
        .RA(RA_1L), .GA(GA_1L), .S3H(S3H_1L)
    );

    initial CLK_6M = 1'b0;
    always #5 CLK_6M = ~CLK_6M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: H is sampled at the edge, then advances.
    task automatic clk1();
        @(posedge CLK_6M);
        #1;
        H = H + 9'd1;
    endtask

    task automatic at_h(input logic [8:0] h);
        H = h;
        clk1();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        CA = a;
        CD = d;
        nLATCH = 1'b0;
        clk1();
        nLATCH = 1'b1;
        clk1();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        nRST = 1'b0;
        FLIP = 1'b0;
        nLATCH = 1'b1;
        CA = '0;
        CD = '0;
        RD = '0;
        H = '0;
        V = '0;

        // Power-on reset
        clk1();
        clk1();
        check("reset_ra", 32'(RA), 32'h0);
        check("reset_ga", 32'(GA), 32'h0);
        check("reset_s3h", 32'(S3H), 32'h0);
        check("reset_ra_1l", 32'(RA_1L), 32'h0);
        nRST = 1'b1;

        // Fetch, scroll 0, V=9
        V = 9'd9;
        RD = 8'h00;
        at_h(9'd0);
        check("fetch_ra_ph0", 32'(RA), 32'h080);
        check("fetch_s3h_ph0", 32'(S3H), 32'h0);
        RD = 8'h5A;
        at_h(9'd1);
        check("fetch_ra_ph1", 32'(RA), 32'h081);
        check("fetch_ga0_ph1", 32'(GA[13:0]), 32'h0);
        RD = 8'h03;
        at_h(9'd2);
        check("fetch_ga0_ph2", 32'(GA[13:0]), 32'h35A2);
        check("fetch_ra_ph2", 32'(RA), 32'h080);
        check("fetch_1l_ra_hold2", 32'(RA_1L), 32'h081);
        check("fetch_1l_ga0", 32'(GA_1L), 32'h35A2);
        RD = 8'hC7;
        at_h(9'd3);
        check("fetch_ra_ph3", 32'(RA), 32'h081);
        check("fetch_s3h_ph3", 32'(S3H), 32'h1);
        check("fetch_ga1_ph3", 32'(GA[27:14]), 32'h0);
        check("fetch_1l_ra_hold3", 32'(RA_1L), 32'h081);
        RD = 8'h01;
        at_h(9'd4);
        check("fetch_ga1_ph0", 32'(GA[27:14]), 32'h1C72);
        check("fetch_s3h_after", 32'(S3H), 32'h0);

        // Reset mid-line
        RD = 8'h00;
        at_h(9'd3);
        H = 9'd2;
        #2;
        nRST = 1'b0;
        #1;
        check("midrst_ra", 32'(RA), 32'h0);
        check("midrst_ga", 32'(GA), 32'h0);
        check("midrst_s3h", 32'(S3H), 32'h0);
        clk1();
        clk1();
        nRST = 1'b1;
        at_h(9'd0);
        check("midrst_ra_ph0", 32'(RA), 32'h080);
        check("midrst_ga_ph0", 32'(GA), 32'h0);
        RD = 8'h11;
        at_h(9'd1);
        check("midrst_ga0_ph1", 32'(GA[13:0]), 32'h0);
        RD = 8'h02;
        at_h(9'd2);
        check("midrst_ga0_ph2", 32'(GA[13:0]), 32'h2112);

        // Scroll commit timing
        V = 9'd0;
        H = 9'd100;
        wr(3'b000, 8'h10);
        at_h(9'd200);
        check("commit_before", 32'(RA), 32'h032);
        at_h(9'd384);
        check("commit_edge_old", 32'(RA), 32'h060);
        at_h(9'd388);
        check("commit_after", 32'(RA), 32'h064);
        CA = 3'b000;
        CD = 8'h30;
        nLATCH = 1'b0;
        H = 9'd384;
        clk1();
        nLATCH = 1'b1;
        clk1();
        at_h(9'd388);
        check("commit_samewr_hold", 32'(RA), 32'h064);
        at_h(9'd384);
        at_h(9'd388);
        check("commit_samewr_next", 32'(RA), 32'h06C);

        // Ninth bit and mod-512 wrap
        H = 9'd100;
        wr(3'b000, 8'hFF);
        wr(3'b001, 8'h01);
        wr(3'b010, 8'hF8);
        V = 9'h010;
        at_h(9'd384);
        at_h(9'd0);
        check("wrap_h0", 32'(RA), 32'h0FE);
        at_h(9'd4);
        check("wrap_h4", 32'(RA), 32'h080);

        // Screen flip
        H = 9'd100;
        wr(3'b000, 8'h00);
        wr(3'b001, 8'h00);
        wr(3'b010, 8'h00);
        V = 9'd0;
        at_h(9'd384);
        FLIP = 1'b1;
        RD = 8'h00;
        at_h(9'd0);
        check("flip_ra_h0", 32'(RA), 32'(EXP_FLIP_RA0));
        RD = 8'hAB;
        at_h(9'd1);
        RD = 8'h00;
        at_h(9'd2);
        check("flip_ga0", 32'(GA[13:0]), 32'(EXP_FLIP_GA0));
        at_h(9'd4);
        check("flip_ra_h4", 32'(RA), 32'(EXP_FLIP_RA4));
        FLIP = 1'b0;

        // Held strobe, layer-1 select
        H = 9'd100;
        CA = 3'b100;
        nLATCH = 1'b0;
        for (int i = 0; i < 5; i++) begin
            CD = 8'(8 * (i + 1));
            clk1();
        end
        nLATCH = 1'b1;
        clk1();
        at_h(9'd384);
        at_h(9'd0);
        check("sel_l0_untouched", 32'(RA), 32'h000);
        check("sel_1l_h0", 32'(RA_1L), 32'h000);
        at_h(9'd1);
        check("sel_1l_h1", 32'(RA_1L), 32'h001);
        at_h(9'd2);
        check("sel_l1_once", 32'(RA), 32'h002);
        check("sel_1l_h2", 32'(RA_1L), 32'h001);
        at_h(9'd3);
        check("sel_l1_odd", 32'(RA), 32'h003);
        check("sel_1l_h3", 32'(RA_1L), 32'h001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
